warp_imem: RTL
==============

Name: warp_imem

Overview:
Instruction-memory responder for the hart fetch port. It answers every `o_imem_ren`/`o_imem_raddr` request from `warp_hart` with a 64-bit fetch packet (two RV instructions, lower word at the lower address) on `i_imem_valid`/`i_imem_rdata`, after a fixed, configurable latency. It is backed by a word-addressed array that is preloaded through a side write port. It is used in hart simulation benches and as the fetch-side model for FPGA bring-up.

Parameters:
- BASE_ADDR, 64'h8000000000, byte address of memory word 0; matches hart RESET_ADDR.
- DEPTH, 1024, number of 64-bit words; power of two, at least 2.
- LATENCY, 1, cycles from request edge to response; legal range 1..4, elaboration error otherwise.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_ren  in  1  fetch request, driven by hart `o_imem_ren`.
- i_raddr  in  64  fetch byte address, driven by hart `o_imem_raddr`.
- o_valid  out  1  response valid, drives hart `i_imem_valid`.
- o_rdata  out  64  fetch packet, drives hart `i_imem_rdata`.
- o_fault  out  1  response is misaligned or out of range; qualified by o_valid.
- i_load_en  in  1  preload write enable.
- i_load_idx  in  $clog2(DEPTH)  preload word index.
- i_load_data  in  64  preload data.
- o_fetch_count  out  32  number of good (non-faulting) responses delivered.

Behaviour:
- No backpressure. A request is accepted on every edge where i_ren=1 and i_rst=0; back-to-back requests are sustained at one per cycle.
- Address decode:
  - idx = (i_raddr - BASE_ADDR) >> 3.
  - Good when i_raddr[2:0]==0, i_raddr >= BASE_ADDR, and idx < DEPTH.
  - Any other request is a fault.
- Array read happens at the accept edge. The response travels down a LATENCY-deep valid/data/fault delay line.
- Timing: a request accepted at edge t gives o_valid=1 for exactly one cycle, the cycle following edge t+LATENCY-1. With LATENCY=1 that is the cycle right after the request edge. All outputs are registered.
- When o_valid=0: o_rdata=0 and o_fault=0.
- Faulting response: o_valid=1, o_fault=1, o_rdata=0. The array is not read and o_fetch_count does not increment.
- o_fetch_count increments on each good response and saturates at 32'hFFFFFFFF.
- Preload: on an edge with i_load_en=1, mem[i_load_idx] <= i_load_data. Preload is accepted even while i_rst=1, so images can be loaded during reset.
- Load and fetch to the same index on the same edge: the fetch returns the old contents (read-before-write).
- Reset (i_rst=1 at an edge):
  - All delay-line valids, o_valid, o_fault, o_rdata and o_fetch_count clear to 0.
  - Requests in flight are dropped, including reset asserted mid-latency; no stale response appears after reset releases.
  - Array contents are preserved.
  - i_ren is ignored while i_rst=1.
- Request on the edge reset deasserts (i_rst=0, i_ren=1): accepted normally.
- Address arithmetic is done in 64 bits. i_raddr below BASE_ADDR must fault; it must not wrap to a valid index.

Decomposition:
- Package warp_imem_pkg holds:
  - FETCH_W=64 and INSN_W=32 constants;
  - DEFAULT_BASE_ADDR=64'h8000000000;
  - response struct imem_resp_t {valid, fault, data[63:0]}.
- Sub-module warp_imem_pipe: a parameterized LATENCY-stage delay line of imem_resp_t with synchronous active-high flush on i_rst.
- The top level holds decode, the array, the preload port and the counter.

Test Plan:
1. LATENCY=1: preload idx0={32'h08206113,32'h07800093}; hold i_ren=1, i_raddr=64'h8000000000 for one edge -> next cycle o_valid=1, o_rdata=64'h0820611307800093, o_fault=0, o_fetch_count=1; o_valid=0 the cycle after.
2. LATENCY=3: preload idx1=64'h1c20019303206213; requests at 0x8000000000 and 0x8000000008 on consecutive edges -> two consecutive valid cycles starting 3 cycles after the first request, in order, o_fetch_count=2.
3. Faults: requests to 0x8000000004, 0x7FFFFFFFF8 and BASE_ADDR+DEPTH*8 -> each gives o_valid=1, o_fault=1, o_rdata=0; o_fetch_count unchanged.
4. LATENCY=3: request at edge t, i_rst=1 at edge t+1 for one cycle -> o_valid never asserts; counter 0; a fresh request after reset returns the preloaded data, proving the array survived reset.
5. Same edge: i_load_en to idx2 with 64'hAAAA and fetch of 0x8000000010 (old value 64'h5555) -> response 64'h5555; a refetch returns 64'hAAAA.
6. Preload idx3 while i_rst=1, release reset, fetch 0x8000000018 -> the loaded value is returned.

Source files
------------

// File: rtl/warp_imem_pkg.sv
// Shared definitions for the warp_imem instruction-memory responder.
//   FETCH_W / INSN_W   : fetch-packet and instruction widths
//   DEFAULT_BASE_ADDR  : byte address of word 0, matches the hart reset vector
//   imem_resp_t        : one response slot travelling down the latency line
package warp_imem_pkg;

  localparam int FETCH_W = 64;
  localparam int INSN_W  = 32;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h80_0000_0000;

  typedef struct packed {
    logic               valid;
    logic               fault;
    logic [FETCH_W-1:0] data;
  } imem_resp_t;

endpackage

// File: rtl/warp_imem_pipe.sv
// LATENCY-stage delay line for fetch responses.
//   i_clk, i_rst : clock and synchronous active-high flush
//   i_resp       : response formed at the accept edge
//   o_resp       : response after LATENCY register stages
//   o_next       : value that will land in the last stage at the next edge
module warp_imem_pipe
  import warp_imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  imem_resp_t i_resp,
  output imem_resp_t o_resp,
  output imem_resp_t o_next
);

  imem_resp_t stages [LATENCY];

  // Flushing every stage on reset is what drops requests still in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= i_resp;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign o_resp = stages[LATENCY-1];

  // The counter needs to see a response one edge before it becomes visible
  // so that o_fetch_count moves in the same cycle as o_valid.
  generate
    if (LATENCY == 1) begin : g_next_input
      assign o_next = i_resp;
    end else begin : g_next_stage
      assign o_next = stages[LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/warp_imem.sv
// Instruction-memory responder for the hart fetch port.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_ren, i_raddr      : fetch request and byte address from the hart
//   o_valid, o_rdata    : registered response and 64-bit fetch packet
//   o_fault             : misaligned / out-of-range response, qualified by o_valid
//   i_load_en/idx/data  : preload write port (works during reset)
//   o_fetch_count       : saturating count of good responses delivered
module warp_imem
  import warp_imem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ren,
  input  logic [63:0]              i_raddr,
  output logic                     o_valid,
  output logic [63:0]              o_rdata,
  output logic                     o_fault,
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_idx,
  input  logic [63:0]              i_load_data,
  output logic [31:0]              o_fetch_count
);

  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("warp_imem: LATENCY must be in 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("warp_imem: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  logic [63:0]      mem [DEPTH];
  logic [63:0]      offset;
  logic [63:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             good;
  imem_resp_t       req_resp;
  imem_resp_t       out_resp;
  imem_resp_t       next_resp;

  // The range check works on the full 64-bit word offset so that addresses
  // below BASE_ADDR (which wrap to huge offsets) can never alias a real word.
  assign accept   = i_ren & ~i_rst;
  assign offset   = i_raddr - BASE_ADDR;
  assign word_off = offset >> 3;
  assign idx      = word_off[IDX_W-1:0];
  assign good     = (i_raddr[2:0] == 3'b000) && (i_raddr >= BASE_ADDR) &&
                    (word_off < 64'(DEPTH));

  // The array is sampled combinationally into the first pipe stage, so a
  // load to the same word on the same edge is seen only by later fetches.
  always_comb begin
    req_resp = '0;
    if (accept) begin
      req_resp.valid = 1'b1;
      if (good) begin
        req_resp.data = mem[idx];
      end else begin
        req_resp.fault = 1'b1;
      end
    end
  end

  // Preload has no reset so an image can be written while the hart is held.
  always_ff @(posedge i_clk) begin
    if (i_load_en) begin
      mem[i_load_idx] <= i_load_data;
    end
  end

  warp_imem_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_resp (req_resp),
    .o_resp (out_resp),
    .o_next (next_resp)
  );

  // Count good responses as they enter the output stage, holding at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_count <= '0;
    end else if (next_resp.valid && !next_resp.fault && (o_fetch_count != 32'hFFFF_FFFF)) begin
      o_fetch_count <= o_fetch_count + 32'd1;
    end
  end

  assign o_valid = out_resp.valid;
  assign o_fault = out_resp.fault;
  assign o_rdata = out_resp.data;

endmodule
